// File: rtl/ofdm_pkg.sv
// Shared constants for the OFDM transmit chain: code parameters, rate codes and
// the puncturing encoder's FSM encoding.
package ofdm_pkg;

  localparam int unsigned K = 7;
  localparam logic [K-1:0] G0 = 7'o133;
  localparam logic [K-1:0] G1 = 7'o171;

  localparam logic [1:0] RATE_12 = 2'b00;
  localparam logic [1:0] RATE_23 = 2'b01;
  localparam logic [1:0] RATE_34 = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    OUT_A = 2'b01,
    OUT_B = 2'b10
  } state_e;

  // Tap vector is ordered {b, s0, s1, ..., s5} so it lines up with the octal generators.
  function automatic logic parity_tap(logic [K-1:0] vec, logic [K-1:0] gen);
    return ^(vec & gen);
  endfunction

  function automatic logic [1:0] rate_norm(logic [1:0] rate);
    return (rate == 2'b11) ? RATE_12 : rate;
  endfunction

  function automatic logic [1:0] rate_mod(logic [1:0] rate);
    logic [1:0] m;
    unique case (rate)
      RATE_23: m = 2'd2;
      RATE_34: m = 2'd3;
      default: m = 2'd1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/conv_enc_punc_if.sv
// Valid/ready bundle for the puncturing encoder: uncoded bits in, coded bits out.
interface conv_enc_punc_if;
  logic [1:0] di_rate;
  logic       di_start;
  logic       di_bit;
  logic       di_vld;
  logic       do_rdy;
  logic       do_bit;
  logic       do_vld;
  logic       di_rdy;

  modport slave (
    input  di_rate, di_start, di_bit, di_vld, di_rdy,
    output do_rdy, do_bit, do_vld
  );

  modport master (
    output di_rate, di_start, di_bit, di_vld, di_rdy,
    input  do_rdy, do_bit, do_vld
  );
endinterface

// File: rtl/conv_enc_core.sv
// K=7 rate-1/2 convolutional encoder core: shift register plus A/B generation.
// A start bit encodes against an all-zero history.
module conv_enc_core
  import ofdm_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_accept,
  input  logic i_start,
  input  logic i_bit,
  output logic o_a,
  output logic o_b
);

  logic [K-2:0] r_s;
  logic [K-2:0] w_s;
  logic [K-1:0] w_vec;

  assign w_s   = i_start ? '0 : r_s;
  assign w_vec = {i_bit, w_s[0], w_s[1], w_s[2], w_s[3], w_s[4], w_s[5]};
  assign o_a   = parity_tap(w_vec, G0);
  assign o_b   = parity_tap(w_vec, G1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s <= '0;
    end else if (i_accept) begin
      r_s <= {w_s[K-3:0], i_bit};
    end
  end

endmodule

// File: rtl/conv_enc_punc.sv
// Convolutional encoder with 802.11a puncturing (1/2, 2/3, 3/4), serialising the kept
// A/B bits one per clock behind valid/ready handshakes on both sides.
module conv_enc_punc
  import ofdm_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  conv_enc_punc_if.slave  bus
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] r_rate;
  logic [1:0] r_ph;
  logic       r_a;
  logic       r_b;
  logic       r_keep_b;

  logic [1:0] w_rate_eff;
  logic [1:0] w_ph_eff;
  logic [1:0] w_ph_inc;
  logic [1:0] w_ph_nxt;
  logic       w_keep_a;
  logic       w_keep_b;
  logic       w_a;
  logic       w_b;
  logic       w_last;
  logic       w_rdy;
  logic       w_vld;
  logic       w_accept;
  logic       w_consume;
  state_e     w_first;

  conv_enc_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_accept (w_accept),
    .i_start  (bus.di_start),
    .i_bit    (bus.di_bit),
    .o_a      (w_a),
    .o_b      (w_b)
  );

  // A start bit overrides the latched rate and phase for its own puncture decision.
  assign w_rate_eff = bus.di_start ? rate_norm(bus.di_rate) : r_rate;
  assign w_ph_eff   = bus.di_start ? 2'd0 : r_ph;
  assign w_ph_inc   = w_ph_eff + 2'd1;
  assign w_ph_nxt   = (w_ph_inc == rate_mod(w_rate_eff)) ? 2'd0 : w_ph_inc;

  always_comb begin
    w_keep_a = 1'b1;
    w_keep_b = 1'b1;
    if (w_rate_eff != RATE_12 && w_ph_eff == 2'd1) begin
      w_keep_b = 1'b0;
    end
    if (w_rate_eff == RATE_34 && w_ph_eff == 2'd2) begin
      w_keep_a = 1'b0;
    end
  end

  assign w_first   = w_keep_a ? OUT_A : OUT_B;
  assign w_last    = (r_state == OUT_B) || (r_state == OUT_A && !r_keep_b);
  assign w_rdy     = (r_state == EMPTY) || (w_last && bus.di_rdy);
  assign w_vld     = (r_state != EMPTY);
  assign w_accept  = bus.di_vld && w_rdy;
  assign w_consume = w_vld && bus.di_rdy;

  assign bus.do_rdy = w_rdy;
  assign bus.do_vld = w_vld;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = w_first;
        end
      end
      OUT_A: begin
        if (w_consume) begin
          if (r_keep_b) begin
            w_state_nxt = OUT_B;
          end else if (w_accept) begin
            w_state_nxt = w_first;
          end else begin
            w_state_nxt = EMPTY;
          end
        end
      end
      OUT_B: begin
        if (w_consume) begin
          w_state_nxt = w_accept ? w_first : EMPTY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    bus.do_bit = 1'b0;
    if (r_state == OUT_A) begin
      bus.do_bit = r_a;
    end else if (r_state == OUT_B) begin
      bus.do_bit = r_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate   <= RATE_12;
      r_ph     <= 2'd0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_keep_b <= 1'b0;
    end else if (w_accept) begin
      r_rate   <= w_rate_eff;
      r_ph     <= w_ph_nxt;
      r_a      <= w_a;
      r_b      <= w_b;
      r_keep_b <= w_keep_b;
    end
  end

endmodule

// File: doc/conv_enc_punc.md
# conv_enc_punc

Rate-1/2, K=7 convolutional encoder (generators 133/171 octal) with 802.11a puncturing to 2/3 and 3/4, emitting one coded bit per clock. It sits in the transmit chain between the scrambler and the interleaver, and is the encoding counterpart of the receive-side Viterbi ACS/traceback path. Upstream and downstream both use valid/ready handshakes. The block serialises the kept (A, B) bits in A-before-B order.

## Interface
- No parameters. Constraint length and generators are fixed by package constants.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `di_rate`  in  2  code rate: 00 = 1/2, 01 = 2/3, 10 = 3/4, 11 reserved (treated as 1/2). Sampled only on an accepted start bit.
- `di_start`  in  1  marks the first bit of a packet. Qualified by `di_vld`.
- `di_bit`  in  1  uncoded input bit.
- `di_vld`  in  1  upstream valid.
- `do_rdy`  out  1  upstream ready; a bit is accepted when `di_vld && do_rdy`.
- `do_bit`  out  1  coded output bit.
- `do_vld`  out  1  downstream valid.
- `di_rdy`  in  1  downstream ready; a bit is consumed when `do_vld && di_rdy`.

## Operation
- Shift register `s[5:0]`, where `s[0]` is the most recent previous bit. For input `b`:
  - A = b^s1^s2^s4^s5
  - B = b^s0^s1^s2^s5
  - On accept: `s <= {s[4:0], b}`.
- Start bit accepted:
  - A/B are computed with `s` taken as zero.
  - The puncture phase is forced to 0.
  - `di_rate` is latched into `rate_q`.
- Puncture phase counter `ph` has modulus 1 (rate 1/2), 2 (rate 2/3) or 3 (rate 3/4). It advances on every accepted bit and wraps to 0.
- Keep mask per phase:
  - 1/2: AB.
  - 2/3: ph0 AB, ph1 A.
  - 3/4: ph0 AB, ph1 A, ph2 B.
- On accept, A, B and the keep mask are registered into an output buffer.
- FSM states: EMPTY, OUT_A, OUT_B.
  - EMPTY → OUT_A if A is kept, else OUT_B.
  - OUT_A → OUT_B on consume if B is kept.
  - Otherwise a consume of the last kept bit goes to the next bit's first kept state if a bit is accepted that cycle, else to EMPTY.
- `do_rdy = (state == EMPTY) || (last kept bit pending && di_rdy)`. This is a combinational path from `di_rdy` and permits back-to-back operation.
- `do_vld = (state != EMPTY)`. `do_bit` is the buffered A in OUT_A and the buffered B in OUT_B.
- Tail/flush zeros are supplied by the upstream block; this block does not insert them.
- `di_rdy` low holds `do_bit`/`do_vld` stable. No state changes while stalled.
- `di_start` without `di_vld` is ignored.
- A start bit arriving mid-pattern truncates the old pattern: the phase resets and no pad bits are inserted.
- A `di_rate` change without start has no effect.
- Reset values:
  - `s` = 0, `ph` = 0, `rate_q` = 1/2, state = EMPTY.
  - `do_vld` = 0, `do_bit` = 0, `do_rdy` = 1.
- Reset mid-packet discards buffered bits immediately (asynchronous). The first cycle after release is identical to power-up.

## Timing
- Latency: input accepted in cycle n → first coded bit has `do_vld` = 1 in cycle n+1.
- Sustained throughput with `di_rdy` held high:
  - 1/2: 1 input per 2 cycles.
  - 2/3: 2 inputs per 3 cycles.
  - 3/4: 3 inputs per 4 cycles.
  - Output is 100% occupied with no bubbles after the first bit.
- There is no combinational path from `di_vld` or `di_bit` to the outputs.

## Structure
- Shared package `ofdm_pkg` contains:
  - `K = 7`, `G0 = 7'o133`, `G1 = 7'o171`.
  - Rate codes `RATE_12`, `RATE_23`, `RATE_34`.
  - FSM state encoding.
- Sub-module `conv_enc_core` contains the shift register, start clear and A/B generation.
- The top level contains the puncture counter, output buffer, FSM and handshakes.

## Test plan
- Rate 1/2 impulse: start with `di_bit` 1, then 6 zeros, `di_rdy` = 1.
  - Output is 11 01 11 11 00 10 11 (14 bits, `do_vld` continuous).
  - `do_rdy` pulses every 2nd cycle.
- Rate 3/4 impulse: start 1, then 5 zeros.
  - Output is 1,1,0,1,1,1,0,0 (8 bits for 6 inputs).
  - No gaps in `do_vld`.
- Rate 2/3, 4 random bits versus a reference model:
  - 6 output bits.
  - B of odd-indexed inputs is absent.
- Backpressure: rate 1/2 with `di_rdy` toggled pseudo-randomly.
  - Output stream is identical to the unstalled run.
  - `do_bit` is stable while `do_vld && !di_rdy`.
  - No input is lost or duplicated.
- Start mid-pattern: rate 3/4, 2 bits, then start with rate 1/2.
  - Shift register is treated as zero.
  - Output after restart matches a fresh packet.
- Asynchronous reset asserted while in OUT_B:
  - `do_vld` drops immediately and `do_rdy` = 1.
  - After release, the rate-1/2 impulse test passes.
